// File: rtl/uart_loader_if.sv
// uart_loader_if: programming-port bundle between the serial loader and the CPU memories.
interface uart_loader_if;
    logic        upg_rst;
    logic        upg_clk;
    logic        upg_wen;
    logic [14:0] upg_adr;
    logic [31:0] upg_dat;
    logic        upg_done;
    modport master (output upg_rst, upg_clk, upg_wen, upg_adr, upg_dat, upg_done);
    modport slave  (input  upg_rst, upg_clk, upg_wen, upg_adr, upg_dat, upg_done);
endinterface

// File: rtl/uart_loader.sv
// uart_loader: 8N1 UART receiver feeding a framed loader that writes little-endian
// 32-bit words into instruction (region 0) or data (region 1) memory.
module uart_loader #(
    parameter int CLKS_PER_BIT = 200,
    parameter int TIMEOUT_BITS = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          rx,
    uart_loader_if.master upg,
    output logic          busy_o,
    output logic          err_o
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int TO = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TW = $clog2(TO);

    typedef enum logic [2:0] {IDLE, HDR, SECT, NLO, NHI, DATA, DONE} state_t;

    logic [2:0]    sync_q;
    logic          rx_act_q, rx_act_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [3:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_sh_q, rx_sh_d;
    logic          bv_q, bv_d, fe;
    logic          line, fall;

    state_t        st_q, st_d;
    logic          region_q, region_d, last_q, last_d;
    logic [15:0]   n_q, n_d;
    logic [13:0]   idx_q, idx_d;
    logic [1:0]    bc_q, bc_d;
    logic [31:0]   word_q, word_d, dat_q, dat_d;
    logic [14:0]   adr_q, adr_d;
    logic          wen_q, wen_d, err_q, err_d, fin_q, fin_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic          active, tmo;

    // sync_q[1] is the synchronized line, sync_q[2] its previous value for edge detection
    assign line = sync_q[1];
    assign fall = sync_q[2] & ~sync_q[1];

    always_comb begin
        rx_act_d = rx_act_q;
        rx_cnt_d = rx_cnt_q;
        rx_bit_d = rx_bit_q;
        rx_sh_d  = rx_sh_q;
        bv_d     = 1'b0;
        fe       = 1'b0;
        if (!rx_act_q) begin
            if (fall) begin
                rx_act_d = 1'b1;
                rx_cnt_d = CW'(CLKS_PER_BIT / 2 - 1);
                rx_bit_d = 4'd0;
            end
        end else if (rx_cnt_q != '0) begin
            rx_cnt_d = rx_cnt_q - 1'b1;
        end else begin
            rx_cnt_d = CW'(CLKS_PER_BIT - 1);
            rx_bit_d = rx_bit_q + 4'd1;
            if (rx_bit_q == 4'd0) begin
                if (line) rx_act_d = 1'b0;
            end else if (rx_bit_q == 4'd9) begin
                rx_act_d = 1'b0;
                bv_d     = line;
                fe       = ~line;
            end else begin
                rx_sh_d = {line, rx_sh_q[7:1]};
            end
        end
    end

    assign active = (st_q == SECT) || (st_q == NLO) || (st_q == NHI) || (st_q == DATA);
    assign tmo    = active && (tmr_q == TW'(TO - 1));

    always_comb begin
        st_d     = st_q;
        region_d = region_q;
        last_d   = last_q;
        n_d      = n_q;
        idx_d    = wen_q ? idx_q + 14'd1 : idx_q;
        bc_d     = bc_q;
        word_d   = word_q;
        wen_d    = 1'b0;
        adr_d    = adr_q;
        dat_d    = dat_q;
        err_d    = err_q;
        fin_d    = 1'b0;
        tmr_d    = (active && !bv_q && !tmo) ? tmr_q + 1'b1 : '0;
        if (start) begin
            st_d  = HDR;
            err_d = 1'b0;
            bc_d  = 2'd0;
        end else if (fin_q) begin
            st_d = DONE;
        end else if (fe || tmo) begin
            err_d = 1'b1;
            if (active) begin
                st_d = HDR;
                bc_d = 2'd0;
            end
        end else if (bv_q) begin
            case (st_q)
                HDR:  st_d = (rx_sh_q == 8'hA5) ? SECT : HDR;
                SECT: begin
                    region_d = rx_sh_q[0];
                    last_d   = rx_sh_q[7];
                    st_d     = NLO;
                end
                NLO: begin
                    n_d[7:0] = rx_sh_q;
                    st_d     = NHI;
                end
                NHI: begin
                    n_d   = {rx_sh_q, n_q[7:0]};
                    idx_d = 14'd0;
                    bc_d  = 2'd0;
                    st_d  = ({rx_sh_q, n_q[7:0]} != 16'd0) ? DATA : (last_q ? DONE : HDR);
                end
                DATA: begin
                    word_d[8*bc_q +: 8] = rx_sh_q;
                    bc_d = bc_q + 2'd1;
                    if (bc_q == 2'd3) begin
                        wen_d = 1'b1;
                        adr_d = {region_q, idx_q};
                        dat_d = {rx_sh_q, word_q[23:0]};
                        n_d   = n_q - 16'd1;
                        // the last write defers DONE by one cycle so it lands after upg_wen
                        if (n_q == 16'd1) begin
                            fin_d = last_q;
                            st_d  = last_q ? DATA : HDR;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= 3'b111;
            rx_act_q <= 1'b0;
            rx_cnt_q <= '0;
            rx_bit_q <= 4'd0;
            rx_sh_q  <= 8'd0;
            bv_q     <= 1'b0;
            st_q     <= IDLE;
            region_q <= 1'b0;
            last_q   <= 1'b0;
            n_q      <= 16'd0;
            idx_q    <= 14'd0;
            bc_q     <= 2'd0;
            word_q   <= 32'd0;
            wen_q    <= 1'b0;
            adr_q    <= 15'd0;
            dat_q    <= 32'd0;
            err_q    <= 1'b0;
            fin_q    <= 1'b0;
            tmr_q    <= '0;
        end else begin
            sync_q   <= {sync_q[1:0], rx};
            rx_act_q <= rx_act_d;
            rx_cnt_q <= rx_cnt_d;
            rx_bit_q <= rx_bit_d;
            rx_sh_q  <= rx_sh_d;
            bv_q     <= bv_d;
            st_q     <= st_d;
            region_q <= region_d;
            last_q   <= last_d;
            n_q      <= n_d;
            idx_q    <= idx_d;
            bc_q     <= bc_d;
            word_q   <= word_d;
            wen_q    <= wen_d;
            adr_q    <= adr_d;
            dat_q    <= dat_d;
            err_q    <= err_d;
            fin_q    <= fin_d;
            tmr_q    <= tmr_d;
        end
    end

    assign upg.upg_clk  = clk;
    assign upg.upg_rst  = (st_q == IDLE) || (st_q == DONE);
    assign upg.upg_done = (st_q == DONE);
    assign upg.upg_wen  = wen_q;
    assign upg.upg_adr  = adr_q;
    assign upg.upg_dat  = dat_q;
    assign busy_o       = ~upg.upg_rst;
    assign err_o        = err_q;
endmodule
